// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain: DEPTH stages of valid/ctrl/result/data/dest fields,
// with stall, flush-to-bubble, youngest-wins write-back forwarding and saturating counters.
module pipe_stage_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_AW-1:0] in_write_reg,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_AW-1:0] out_write_reg,
  input  logic [REG_AW-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned Last = DEPTH - 1;

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];
  logic [DATA_W-1:0] alu_q   [DEPTH];
  logic [DATA_W-1:0] alu_d   [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] wdata_d [DEPTH];
  logic [REG_AW-1:0] wreg_q  [DEPTH];
  logic [REG_AW-1:0] wreg_d  [DEPTH];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      ctrl_d[k]  = ctrl_q[k];
      alu_d[k]   = alu_q[k];
      wdata_d[k] = wdata_q[k];
      wreg_d[k]  = wreg_q[k];
    end
    if (flush) begin
      // Bubbles keep their stale data fields; only valid and ctrl are cleared.
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end
    end else if (!stall) begin
      valid_d[0] = in_valid;
      ctrl_d[0]  = in_valid ? in_ctrl : '0;
      alu_d[0]   = in_alu_result;
      wdata_d[0] = in_write_data;
      wreg_d[0]  = in_write_reg;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        alu_d[k]   = alu_q[k-1];
        wdata_d[k] = wdata_q[k-1];
        wreg_d[k]  = wreg_q[k-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!valid_d[Last] && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        alu_q[k]   <= '0;
        wdata_q[k] <= '0;
        wreg_q[k]  <= '0;
      end
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        ctrl_q[k]  <= ctrl_d[k];
        alu_q[k]   <= alu_d[k];
        wdata_q[k] <= wdata_d[k];
        wreg_q[k]  <= wreg_d[k];
      end
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Scan oldest to youngest so the youngest matching stage is the last assignment.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (valid_q[k] && ctrl_q[k][0] && (wreg_q[k] == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = alu_q[k];
      end
    end
  end

  assign out_valid      = valid_q[Last];
  assign out_ctrl       = ctrl_q[Last];
  assign out_alu_result = alu_q[Last];
  assign out_write_data = wdata_q[Last];
  assign out_write_reg  = wreg_q[Last];
  assign stall_cnt      = stall_cnt_q;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboarded bench for pipe_stage_chain (DEPTH=3, CNT_W=4): directed pass-through, stall,
// flush, forwarding, saturation and asynchronous reset scenarios.
module tb_pipe_stage_chain;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegAw = 5;
  localparam int unsigned CtrlW = 2;
  localparam int unsigned Depth = 3;
  localparam int unsigned CntW  = 4;

  typedef struct packed {
    logic [CtrlW-1:0] ctrl;
    logic [DataW-1:0] alu;
    logic [DataW-1:0] wd;
    logic [RegAw-1:0] wr;
  } item_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             stall, flush;
  logic             in_valid;
  logic [CtrlW-1:0] in_ctrl;
  logic [DataW-1:0] in_alu_result, in_write_data;
  logic [RegAw-1:0] in_write_reg;
  logic             out_valid;
  logic [CtrlW-1:0] out_ctrl;
  logic [DataW-1:0] out_alu_result, out_write_data;
  logic [RegAw-1:0] out_write_reg;
  logic [RegAw-1:0] fwd_addr;
  logic             fwd_hit;
  logic [DataW-1:0] fwd_data;
  logic [CntW-1:0]  stall_cnt, bubble_cnt;

  int    checks   = 0;
  int    failures = 0;
  item_t exp_q[$];
  item_t mon_e;
  logic  adv;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .DATA_W(DataW), .REG_AW(RegAw), .CTRL_W(CtrlW), .DEPTH(Depth), .CNT_W(CntW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ctrl       (in_ctrl),
    .in_alu_result (in_alu_result),
    .in_write_data (in_write_data),
    .in_write_reg  (in_write_reg),
    .out_valid     (out_valid),
    .out_ctrl      (out_ctrl),
    .out_alu_result(out_alu_result),
    .out_write_data(out_write_data),
    .out_write_reg (out_write_reg),
    .fwd_addr      (fwd_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One unstalled, unflushed edge; a valid input becomes an expected output DEPTH edges later.
  task automatic issue(input logic v, input logic [1:0] c, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr);
    item_t it;
    stall = 1'b0; flush = 1'b0;
    in_valid = v; in_ctrl = c; in_alu_result = alu; in_write_data = wd; in_write_reg = wr;
    @(posedge clk);
    if (v) begin
      it.ctrl = c; it.alu = alu; it.wd = wd; it.wr = wr;
      exp_q.push_back(it);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  // Reset pulse placed between clock edges; caller sits at posedge+1.
  task automatic pulse_reset();
    #3 reset_n = 1'b0;
    exp_q.delete();
    #3 reset_n = 1'b1;
  endtask

  // Monitor: after every advancing edge, a valid output must match the oldest expectation.
  always @(posedge clk) begin
    adv = reset_n && !stall && !flush;
    #1;
    if (adv && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got alu 0x%0h with no expected item", out_alu_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_ctrl", 32'(out_ctrl), 32'(mon_e.ctrl));
        check("mon_alu", out_alu_result, mon_e.alu);
        check("mon_wdata", out_write_data, mon_e.wd);
        check("mon_wreg", 32'(out_write_reg), 32'(mon_e.wr));
      end
    end
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_alu_result = '0; in_write_data = '0; in_write_reg = '0;
    fwd_addr = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_alu", out_alu_result, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    reset_n = 1'b1;

    // Pass-through: visible at the third edge, not before.
    issue(1'b1, 2'b01, 32'h0000_00AA, 32'h55, 5'd5);
    check("pt_e1_valid", 32'(out_valid), 32'd0);
    check("pt_fwd_hit_s0", 32'(fwd_hit), 32'd1);
    check("pt_fwd_data_s0", fwd_data, 32'hAA);
    idle(1);
    check("pt_e2_valid", 32'(out_valid), 32'd0);
    idle(1);
    check("pt_e3_valid", 32'(out_valid), 32'd1);
    check("pt_e3_alu", out_alu_result, 32'hAA);
    check("pt_bubble_cnt", 32'(bubble_cnt), 32'd2);

    // Stall hold with changing inputs.
    pulse_reset();
    issue(1'b1, 2'b01, 32'h1234, 32'h0, 5'd3);
    idle(2);
    check("st_loaded", out_alu_result, 32'h1234);
    stall = 1'b1; in_valid = 1'b1; in_ctrl = 2'b01; in_alu_result = 32'hFFFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("st_hold_alu", out_alu_result, 32'h1234);
      check("st_hold_valid", 32'(out_valid), 32'd1);
    end
    check("st_stall_cnt", 32'(stall_cnt), 32'd4);
    check("st_bubble_cnt", 32'(bubble_cnt), 32'd2);
    idle(1);

    // Flush beats stall; in-flight B must never emerge.
    issue(1'b1, 2'b01, 32'h77, 32'h88, 5'd9);
    issue(1'b1, 2'b11, 32'hBB, 32'hCC, 5'd10);
    idle(1);
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    check("fl_pre_bubble", 32'(bubble_cnt), 32'd5);
    stall = 1'b1; flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ctrl", 32'(out_ctrl), 32'd0);
    check("fl_alu_held", out_alu_result, 32'h77);
    check("fl_stall_cnt", 32'(stall_cnt), 32'd4);
    check("fl_bubble_cnt", 32'(bubble_cnt), 32'd6);
    idle(3);
    check("fl_drain_valid", 32'(out_valid), 32'd0);

    // Forwarding.
    pulse_reset();
    issue(1'b1, 2'b01, 32'h11, 32'h0, 5'd7);
    issue(1'b1, 2'b01, 32'h22, 32'h0, 5'd7);
    fwd_addr = 5'd7; #1;
    check("fw_young_hit", 32'(fwd_hit), 32'd1);
    check("fw_young_data", fwd_data, 32'h22);
    fwd_addr = 5'd3; #1;
    check("fw_miss_hit", 32'(fwd_hit), 32'd0);
    check("fw_miss_data", fwd_data, 32'd0);
    issue(1'b1, 2'b01, 32'h33, 32'h0, 5'd0);
    fwd_addr = 5'd0; #1;
    check("fw_r0_hit", 32'(fwd_hit), 32'd0);
    check("fw_r0_data", fwd_data, 32'd0);
    issue(1'b1, 2'b10, 32'h44, 32'h0, 5'd7);
    fwd_addr = 5'd7; #1;
    check("fw_nowrite_skip", fwd_data, 32'h22);
    idle(3);
    issue(1'b0, 2'b01, 32'h55, 32'h0, 5'd7);
    check("fw_bubble_hit", 32'(fwd_hit), 32'd0);
    idle(2);
    check("fw_bubble_ctrl", 32'(out_ctrl), 32'd0);

    // Counter saturation.
    pulse_reset();
    stall = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat_bubble_cnt", 32'(bubble_cnt), 32'd15);
    stall = 1'b0;

    // Asynchronous reset with data in flight.
    issue(1'b1, 2'b01, 32'h99, 32'hAB, 5'd4);
    idle(2);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    fwd_addr = 5'd4;
    #3 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_alu", out_alu_result, 32'd0);
    check("ar_wdata", out_write_data, 32'd0);
    check("ar_wreg", 32'(out_write_reg), 32'd0);
    check("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    check("ar_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("ar_fwd_hit", 32'(fwd_hit), 32'd0);
    #2 reset_n = 1'b1;
    issue(1'b1, 2'b11, 32'hC0DE, 32'h1, 5'd2);
    idle(3);
    check("end_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
